// File: rtl/cpu_pkg.sv
// Shared pipeline types and constants used by the fetch stage and its IF/ID register.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  // Instruction fetch is word-granular; the low two bits of a byte target are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Control, instruction-memory and IF/ID signals of the fetch stage, grouped as one bundle.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_instr;
  logic [XLEN-1:0] pc;
  logic            if_id_valid;
  logic [XLEN-1:0] if_id_pc;
  logic [XLEN-1:0] if_id_instr;
  logic            misaligned;
  logic            halted;
  logic [XLEN-1:0] fetch_count;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_instr,
    output imem_addr, pc, if_id_valid, if_id_pc, if_id_instr,
           misaligned, halted, fetch_count
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_instr,
    input  imem_addr, pc, if_id_valid, if_id_pc, if_id_instr,
           misaligned, halted, fetch_count
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched word with its PC, holds otherwise, flushes to a NOP bubble.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  logic            valid_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] instr_reg;

  // Flush beats load so a redirect can never let a wrong-path word through.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      pc_reg    <= '0;
      instr_reg <= NOP;
    end else if (flush) begin
      valid_reg <= 1'b0;
      pc_reg    <= '0;
      instr_reg <= NOP;
    end else if (load) begin
      valid_reg <= 1'b1;
      pc_reg    <= load_pc;
      instr_reg <= load_instr;
    end
  end

  assign valid = valid_reg;
  assign pc    = pc_reg;
  assign instr = instr_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, run/halt FSM, delivered-instruction counter, and the IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] fetch_count_reg, fetch_count_next;
  logic            misaligned_reg, misaligned_next;
  logic            ifid_load;
  logic            ifid_flush;
  logic [XLEN-1:0] word_index;
  logic            in_range;

  assign word_index = {2'b00, pc_reg[XLEN-1:2]};
  assign in_range   = (word_index < MEM_DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= RUN;
      pc_reg          <= RESET_PC;
      fetch_count_reg <= '0;
      misaligned_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      fetch_count_reg <= fetch_count_next;
      misaligned_reg  <= misaligned_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    fetch_count_next = fetch_count_reg;
    misaligned_next  = 1'b0;
    ifid_load        = 1'b0;
    ifid_flush       = 1'b0;

    if (bus.redirect_valid) begin
      // A redirect restarts fetch from any state and ignores stall.
      pc_next         = align_word(bus.redirect_pc);
      ifid_flush      = 1'b1;
      state_next      = RUN;
      misaligned_next = |bus.redirect_pc[1:0];
    end else begin
      case (state_reg)
        RUN: begin
          if (!bus.stall) begin
            if (in_range) begin
              ifid_load        = 1'b1;
              pc_next          = pc_reg + PC_STEP;
              fetch_count_next = fetch_count_reg + 32'd1;
            end else begin
              // Ran off the populated store: emit a bubble and park on this PC.
              ifid_flush = 1'b1;
              state_next = HALTED;
            end
          end
        end
        HALTED: begin
          state_next = HALTED;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ifid_load),
    .flush      (ifid_flush),
    .load_pc    (pc_reg),
    .load_instr (bus.imem_instr),
    .valid      (bus.if_id_valid),
    .pc         (bus.if_id_pc),
    .instr      (bus.if_id_instr)
  );

  assign bus.imem_addr   = word_index;
  assign bus.pc          = pc_reg;
  assign bus.fetch_count = fetch_count_reg;
  assign bus.misaligned  = misaligned_reg;
  assign bus.halted      = (state_reg == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/redirect/reset traffic.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          MEM_DEPTH = 30;

  logic clk;
  logic rst_n;
  fetch_stage_if bus ();

  logic [31:0] mem [MEM_DEPTH];

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .MEM_DEPTH (MEM_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Out-of-range reads return a marker word that must never reach IF/ID.
  assign bus.imem_instr = (bus.imem_addr < MEM_DEPTH) ? mem[bus.imem_addr[4:0]] : 32'hBAD0_BAD0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state, written from the behavioural rules only.
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_ifpc;
  logic        m_ifpc_known;
  logic [31:0] m_instr;
  logic        m_mis;
  logic        m_halted;
  logic [31:0] m_count;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  task automatic model_edge(input logic s, input logic rv, input logic [31:0] rp, input logic rn);
    int widx;
    if (!rn) begin
      m_pc = RESET_PC; m_valid = 0; m_ifpc = 0; m_ifpc_known = 1;
      m_instr = 0; m_mis = 0; m_halted = 0; m_count = 0;
    end else if (rv) begin
      m_pc = (rp / 4) * 4; m_valid = 0; m_ifpc = 0; m_ifpc_known = 1;
      m_instr = 0; m_halted = 0; m_mis = (rp % 4) != 0;
    end else begin
      m_mis = 0;
      widx = int'(m_pc / 4);
      if (m_halted || s) begin
        // nothing moves
      end else if (m_pc / 4 < MEM_DEPTH) begin
        m_ifpc = m_pc; m_ifpc_known = 1; m_instr = mem[widx]; m_valid = 1;
        m_pc = m_pc + 4; m_count = m_count + 1;
      end else begin
        m_valid = 0; m_instr = 0; m_halted = 1; m_ifpc_known = 0;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("pc", bus.pc, m_pc);
    check_eq("imem_addr", bus.imem_addr, m_pc / 4);
    check_eq("if_id_valid", {31'b0, bus.if_id_valid}, {31'b0, m_valid});
    check_eq("if_id_instr", bus.if_id_instr, m_instr);
    if (m_ifpc_known) check_eq("if_id_pc", bus.if_id_pc, m_ifpc);
    check_eq("misaligned", {31'b0, bus.misaligned}, {31'b0, m_mis});
    check_eq("halted", {31'b0, bus.halted}, {31'b0, m_halted});
    check_eq("fetch_count", bus.fetch_count, m_count);
  endtask

  task automatic step(input logic s, input logic rv, input logic [31:0] rp, input logic rn);
    bus.stall = s;
    bus.redirect_valid = rv;
    bus.redirect_pc = rp;
    rst_n = rn;
    model_edge(s, rv, rp, rn);
    @(posedge clk);
    #1;
    compare_all();
    $display("step rst_n=%0b stall=%0b redir=%0b rp=%h -> pc=%h v=%0b ifpc=%h instr=%h mis=%0b halt=%0b cnt=%0d",
             rn, s, rv, rp, bus.pc, bus.if_id_valid, bus.if_id_pc, bus.if_id_instr,
             bus.misaligned, bus.halted, bus.fetch_count);
  endtask

  initial begin
    logic s, rv, rn;
    logic [31:0] rp;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = $urandom;
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0; rst_n = 0;

    // Reset, then free-run.
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    // Hold for three stalled cycles at pc 0x10, then resume.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
    check_eq("stall_hold_pc", bus.pc, 32'h10);
    step(0, 0, 0, 1);
    // Redirect beats a simultaneous stall.
    step(1, 1, 32'h40, 1);
    step(0, 0, 0, 1);
    check_eq("redirect_target_fetched", bus.if_id_pc, 32'h40);

    // Fresh run to the end of the store.
    step(0, 0, 0, 0);
    for (int i = 0; i < 64 && !bus.halted; i++) step(0, 0, 0, 1);
    check_eq("halt_reached", {31'b0, bus.halted}, 32'd1);
    check_eq("halt_pc", bus.pc, 32'h78);
    check_eq("halt_count", bus.fetch_count, 32'd30);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);

    // Misaligned restart from the halted state.
    step(0, 1, 32'h0A, 1);
    check_eq("restart_pc", bus.pc, 32'h08);
    check_eq("restart_misaligned", {31'b0, bus.misaligned}, 32'd1);
    step(0, 0, 0, 1);
    check_eq("misaligned_pulse", {31'b0, bus.misaligned}, 32'd0);
    check_eq("restart_word2_instr", bus.if_id_instr, mem[2]);

    // Reset wins over a redirect in the same cycle.
    step(1, 1, 32'h24, 0);
    check_eq("reset_over_redirect", bus.pc, RESET_PC);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 9) == 0);
      rn = ($urandom_range(0, 49) != 0);
      rp = $urandom_range(0, (MEM_DEPTH + 3) * 4 - 1);
      step(s, rv, rp, rn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the single-issue pipeline. Owns the program counter, drives the word-indexed address of the combinational instruction memory, and captures the returned word with its PC into the IF/ID pipeline register. Handles decode/execute stalls, taken-branch/jump redirects, and halts cleanly when the PC runs past the end of the populated instruction store.

## Interface
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset
- MEM_DEPTH, 30, number of 32-bit words in instruction memory; word index >= MEM_DEPTH is end-of-program

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- stall  in  1  hold PC and IF/ID (load-use / structural stall from decode)
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_pc  in  32  byte target address
- imem_addr  out  32  word index to instruction memory, = {2'b00, pc[31:2]}
- imem_instr  in  32  instruction word, combinational from imem_addr
- pc  out  32  current fetch PC (byte address)
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  32  byte PC of if_id_instr
- if_id_instr  out  32  fetched instruction; NOP (32'h0) when invalid
- misaligned  out  1  one-cycle pulse: last accepted redirect_pc had nonzero [1:0]
- halted  out  1  fetch has stopped at end of program
- fetch_count  out  32  count of instructions delivered into IF/ID

## Operation
- States: RUN, HALTED. Reset → RUN.
- Priority per edge: reset > redirect > stall > normal advance > end-of-program check.
- RUN, normal (no stall, no redirect, pc[31:2] < MEM_DEPTH): if_id_instr<=imem_instr, if_id_pc<=pc, if_id_valid<=1, pc<=pc+4, fetch_count+=1.
- RUN, pc[31:2] >= MEM_DEPTH (no redirect): if_id_valid<=0, if_id_instr<=NOP, pc holds, state→HALTED, halted<=1.
- Stall (no redirect): pc, if_id_*, fetch_count, state all hold.
- Redirect (any state, stall ignored): pc<={redirect_pc[31:2],2'b00}; IF/ID flushed (valid 0, instr NOP, if_id_pc 0); state→RUN, halted<=0; misaligned<=|redirect_pc[1:0].
- HALTED without redirect: everything holds; stall has no effect.
- misaligned is 0 on every edge without redirect.
- pc+4 wraps modulo 2^32; fetch_count wraps modulo 2^32.

## Timing
- Reset values (after rising edge with rst_n=0): pc=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_instr=0, misaligned=0, halted=0, fetch_count=0, state RUN.
- imem_addr is purely combinational from pc; no registered address.
- Latency: instruction at PC P appears on if_id_* one edge after pc=P.
- Redirect in cycle n: target PC visible cycle n+1, its instruction in IF/ID cycle n+2; exactly one bubble.
- End-of-program: bubble and halted both appear on the same edge; PC stays at first out-of-range address.
- Reset mid-stall or mid-redirect: reset wins, no partial update.

## Structure
- Shared package cpu_pkg: XLEN=32, NOP=32'h0000_0000, PC_STEP=4, fetch state enum {RUN, HALTED}.
- One sub-module: if_id_reg (valid/pc/instr register with load, hold, flush inputs, reset to NOP); fetch_stage keeps PC, FSM, counter.

## Test plan
- Reset then 5 free-running cycles, RESET_PC=0 -> imem_addr 0,1,2,3,4; if_id_pc 0,4,8,12 with matching words; fetch_count=4 after cycle 5.
- stall high for 3 cycles with pc=0x10 -> pc, if_id_*, fetch_count unchanged for 3 cycles; resumes at 0x10.
- redirect_valid with redirect_pc=0x40 while stall=1 -> next cycle pc=0x40, if_id_valid=0, if_id_instr=0; two cycles later if_id_pc=0x40.
- Free-run to end, MEM_DEPTH=30 -> after word 29 (pc 0x74) delivered, pc=0x78 holds, if_id_valid=0, halted=1, fetch_count=30.
- While halted, redirect_pc=0x0A -> pc=0x08, misaligned=1 for one cycle, halted=0, fetch restarts at word 2.
- rst_n low during redirect cycle -> all outputs equal reset values next cycle, pc=RESET_PC.
